// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: status-register bit layout, default widths,
// and the 4-bit status vector type.
package arm_pkg;

  localparam int Z_BIT = 3;
  localparam int C_BIT = 2;
  localparam int N_BIT = 1;
  localparam int V_BIT = 0;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 4;

  typedef logic [3:0] status_t;

endpackage

// File: rtl/status_reg.sv
// Architectural status register {z,c,n,v}: loads d on edges with ld high.
// Latency 1 cycle, no combinational d->q path; no backpressure, holds when ld low.
module status_reg
  import arm_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    ld,
  input  status_t d,
  output status_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exe_mem_stage_reg.sv
// EXE/MEM pipeline register plus status register, 1-cycle latency; freeze holds everything,
// flush or !exe_valid inserts a bubble. EXE_MEM_PERF_EN adds retired/bubble counters.
module exe_mem_stage_reg
  import arm_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              exe_valid,
  input  logic              exe_s,
  input  logic [3:0]        exe_status,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] st_val,
  input  logic [REG_W-1:0]  dest,
  input  logic              wb_en,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  output logic [3:0]        sr,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_st_val,
  output logic [REG_W-1:0]  mem_dest,
  output logic              mem_wb_en,
  output logic              mem_r_en_o,
  output logic              mem_w_en_o
`ifdef EXE_MEM_PERF_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  logic load_vld;
  logic sr_ld;

  // A real instruction advances only when the stage is neither frozen nor squashed.
  assign load_vld = exe_valid & ~flush & ~freeze;
  assign sr_ld    = load_vld & exe_s;

  status_reg u_status_reg (
    .clk (clk),
    .rst (rst),
    .ld  (sr_ld),
    .d   (exe_status),
    .q   (sr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_st_val     <= '0;
      mem_dest       <= '0;
      mem_wb_en      <= 1'b0;
      mem_r_en_o     <= 1'b0;
      mem_w_en_o     <= 1'b0;
    end else if (!freeze) begin
      if (load_vld) begin
        mem_valid      <= 1'b1;
        mem_alu_result <= alu_result;
        mem_st_val     <= st_val;
        mem_dest       <= dest;
        mem_wb_en      <= wb_en;
        mem_r_en_o     <= mem_r_en;
        mem_w_en_o     <= mem_w_en;
      end else begin
        // Bubble: only control is cleared, data fields keep their last values.
        mem_valid  <= 1'b0;
        mem_wb_en  <= 1'b0;
        mem_r_en_o <= 1'b0;
        mem_w_en_o <= 1'b0;
      end
    end
  end

`ifdef EXE_MEM_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      bubble_cnt  <= '0;
    end else if (!freeze) begin
      if (load_vld) begin
        retired_cnt <= retired_cnt + 32'd1;
      end else begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Directed self-checking bench for exe_mem_stage_reg.
module tb_exe_mem_stage_reg;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        flush;
  logic        exe_valid;
  logic        exe_s;
  logic [3:0]  exe_status;
  logic [31:0] alu_result;
  logic [31:0] st_val;
  logic [3:0]  dest;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [3:0]  sr;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_st_val;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        mem_r_en_o;
  logic        mem_w_en_o;
`ifdef EXE_MEM_PERF_EN
  logic [31:0] retired_cnt;
  logic [31:0] bubble_cnt;
`endif

  int checks;
  int failures;

  exe_mem_stage_reg dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .flush          (flush),
    .exe_valid      (exe_valid),
    .exe_s          (exe_s),
    .exe_status     (exe_status),
    .alu_result     (alu_result),
    .st_val         (st_val),
    .dest           (dest),
    .wb_en          (wb_en),
    .mem_r_en       (mem_r_en),
    .mem_w_en       (mem_w_en),
    .sr             (sr),
    .mem_valid      (mem_valid),
    .mem_alu_result (mem_alu_result),
    .mem_st_val     (mem_st_val),
    .mem_dest       (mem_dest),
    .mem_wb_en      (mem_wb_en),
    .mem_r_en_o     (mem_r_en_o),
    .mem_w_en_o     (mem_w_en_o)
`ifdef EXE_MEM_PERF_EN
    ,
    .retired_cnt    (retired_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    freeze     = 1'b0;
    flush      = 1'b0;
    exe_valid  = 1'b0;
    exe_s      = 1'b0;
    exe_status = 4'b0000;
    alu_result = 32'h0;
    st_val     = 32'h0;
    dest       = 4'd0;
    wb_en      = 1'b0;
    mem_r_en   = 1'b0;
    mem_w_en   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++;
    if (sr !== 4'b0000 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_init sr=%b valid=%b expected sr=0000 valid=0", sr, mem_valid);
    end
    step();
    rst = 1'b0;
    exe_valid  = 1'b1;
    exe_s      = 1'b1;
    exe_status = 4'b1111;
    alu_result = 32'h1111_2222;
    dest       = 4'd9;
    wb_en      = 1'b1;
    step();
    checks++;
    if (sr !== 4'b1111 || mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload sr=%b valid=%b expected sr=1111 valid=1", sr, mem_valid);
    end
    idle_inputs();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (sr !== 4'b0000 || mem_valid !== 1'b0 || mem_wb_en !== 1'b0 ||
        mem_alu_result !== 32'h0 || mem_dest !== 4'd0) begin
      failures++;
      $display("FAIL reset_async sr=%b valid=%b wb=%b alu=%h dest=%0d expected all zero",
               sr, mem_valid, mem_wb_en, mem_alu_result, mem_dest);
    end
    #1;
    rst = 1'b0;
    step();
    checks++;
    if (mem_valid !== 1'b0 || mem_r_en_o !== 1'b0 || mem_w_en_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle valid=%b r=%b w=%b expected 0 0 0", mem_valid, mem_r_en_o, mem_w_en_o);
    end
  endtask

  task automatic test_normal_load();
    idle_inputs();
    exe_valid  = 1'b1;
    exe_s      = 1'b1;
    exe_status = 4'b0100;
    alu_result = 32'hFFFF_FFFF;
    st_val     = 32'hCAFE_0001;
    dest       = 4'd3;
    wb_en      = 1'b1;
    step();
    checks++;
    if (sr !== 4'b0100) begin
      failures++;
      $display("FAIL load_sr got=%b expected=0100", sr);
    end
    checks++;
    if (mem_alu_result !== 32'hFFFF_FFFF || mem_st_val !== 32'hCAFE_0001 || mem_dest !== 4'd3) begin
      failures++;
      $display("FAIL load_data alu=%h st=%h dest=%0d expected ffffffff cafe0001 3",
               mem_alu_result, mem_st_val, mem_dest);
    end
    checks++;
    if (mem_valid !== 1'b1 || mem_wb_en !== 1'b1 || mem_r_en_o !== 1'b0 || mem_w_en_o !== 1'b0) begin
      failures++;
      $display("FAIL load_ctrl valid=%b wb=%b r=%b w=%b expected 1 1 0 0",
               mem_valid, mem_wb_en, mem_r_en_o, mem_w_en_o);
    end
  endtask

  task automatic test_s_gating();
    idle_inputs();
    exe_valid  = 1'b1;
    exe_s      = 1'b0;
    exe_status = 4'b1000;
    alu_result = 32'h0000_1234;
    dest       = 4'd5;
    mem_r_en   = 1'b1;
    step();
    checks++;
    if (sr !== 4'b0100) begin
      failures++;
      $display("FAIL sgate_sr got=%b expected=0100", sr);
    end
    checks++;
    if (mem_valid !== 1'b1 || mem_alu_result !== 32'h0000_1234 || mem_dest !== 4'd5 ||
        mem_r_en_o !== 1'b1 || mem_wb_en !== 1'b0) begin
      failures++;
      $display("FAIL sgate_mem valid=%b alu=%h dest=%0d r=%b wb=%b expected 1 00001234 5 1 0",
               mem_valid, mem_alu_result, mem_dest, mem_r_en_o, mem_wb_en);
    end
  endtask

  task automatic test_flush();
    idle_inputs();
    flush      = 1'b1;
    exe_valid  = 1'b1;
    exe_s      = 1'b1;
    exe_status = 4'b0001;
    alu_result = 32'hDEAD_BEEF;
    dest       = 4'd12;
    wb_en      = 1'b1;
    mem_w_en   = 1'b1;
    step();
    checks++;
    if (mem_valid !== 1'b0 || mem_w_en_o !== 1'b0 || mem_r_en_o !== 1'b0 || mem_wb_en !== 1'b0) begin
      failures++;
      $display("FAIL flush_ctrl valid=%b w=%b r=%b wb=%b expected 0 0 0 0",
               mem_valid, mem_w_en_o, mem_r_en_o, mem_wb_en);
    end
    checks++;
    if (sr !== 4'b0100) begin
      failures++;
      $display("FAIL flush_sr got=%b expected=0100", sr);
    end
    checks++;
    if (mem_alu_result !== 32'h0000_1234 || mem_dest !== 4'd5) begin
      failures++;
      $display("FAIL flush_data alu=%h dest=%0d expected 00001234 5", mem_alu_result, mem_dest);
    end
  endtask

  task automatic test_freeze_flush();
    idle_inputs();
    exe_valid  = 1'b1;
    exe_s      = 1'b1;
    exe_status = 4'b0010;
    alu_result = 32'h0000_A5A5;
    st_val     = 32'h0000_5A5A;
    dest       = 4'd7;
    wb_en      = 1'b1;
    mem_w_en   = 1'b1;
    step();
    checks++;
    if (sr !== 4'b0010 || mem_valid !== 1'b1 || mem_w_en_o !== 1'b1) begin
      failures++;
      $display("FAIL frz_setup sr=%b valid=%b w=%b expected 0010 1 1", sr, mem_valid, mem_w_en_o);
    end
    freeze = 1'b1;
    flush  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exe_status = 4'(4'b1001 + i);
      alu_result = 32'h7000_0000 + i;
      st_val     = 32'h8000_0000 + i;
      dest       = 4'(i + 1);
      wb_en      = i[0];
      mem_r_en   = 1'b1;
      mem_w_en   = i[0];
      step();
      checks++;
      if (sr !== 4'b0010 || mem_valid !== 1'b1 || mem_alu_result !== 32'h0000_A5A5 ||
          mem_st_val !== 32'h0000_5A5A || mem_dest !== 4'd7 || mem_wb_en !== 1'b1 ||
          mem_r_en_o !== 1'b0 || mem_w_en_o !== 1'b1) begin
        failures++;
        $display("FAIL frz_hold_%0d sr=%b v=%b alu=%h st=%h d=%0d wb=%b r=%b w=%b expected 0010 1 a5a5 5a5a 7 1 0 1",
                 i, sr, mem_valid, mem_alu_result, mem_st_val, mem_dest, mem_wb_en, mem_r_en_o, mem_w_en_o);
      end
    end
    freeze = 1'b0;
    step();
    checks++;
    if (mem_valid !== 1'b0 || mem_w_en_o !== 1'b0 || mem_wb_en !== 1'b0 || mem_r_en_o !== 1'b0 ||
        sr !== 4'b0010 || mem_alu_result !== 32'h0000_A5A5) begin
      failures++;
      $display("FAIL frz_release v=%b w=%b wb=%b r=%b sr=%b alu=%h expected 0 0 0 0 0010 0000a5a5",
               mem_valid, mem_w_en_o, mem_wb_en, mem_r_en_o, sr, mem_alu_result);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    exe_valid  = 1'b1;
    exe_s      = 1'b1;
    exe_status = 4'b0100;
    alu_result = 32'h0000_0010;
    step();
    checks++;
    if (sr[2] !== 1'b1 || sr !== 4'b0100) begin
      failures++;
      $display("FAIL b2b_carry sr=%b expected=0100", sr);
    end
    exe_status = 4'b0000;
    alu_result = 32'h0000_0011;
    step();
    checks++;
    if (sr !== 4'b0000 || mem_alu_result !== 32'h0000_0011 || mem_valid !== 1'b1) begin
      failures++;
      $display("FAIL b2b_adc sr=%b alu=%h v=%b expected 0000 00000011 1", sr, mem_alu_result, mem_valid);
    end
    exe_valid  = 1'b0;
    exe_s      = 1'b1;
    exe_status = 4'b1111;
    alu_result = 32'h0000_0099;
    wb_en      = 1'b1;
    step();
    checks++;
    if (sr !== 4'b0000 || mem_valid !== 1'b0 || mem_wb_en !== 1'b0 || mem_alu_result !== 32'h0000_0011) begin
      failures++;
      $display("FAIL b2b_bubble sr=%b v=%b wb=%b alu=%h expected 0000 0 0 00000011",
               sr, mem_valid, mem_wb_en, mem_alu_result);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_normal_load();
    test_s_gating();
    test_flush();
    test_freeze_flush();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
